// File: rtl/mem_responder.sv
// Fixed-latency memory responder for the processor/memory bus: issues tags, services stores, returns load data.
// Optional feature: define MEM_RANDOM_REFUSE_EN to refuse commands pseudo-randomly via a 4-bit LFSR.
module mem_responder #(
    parameter int MEM_LATENCY = 4,
    parameter int MEM_WORDS   = 8192,
    parameter int XLEN        = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      proc2mem_command,
    input  logic [XLEN-1:0] proc2mem_addr,
    input  logic [63:0]     proc2mem_data,
    output logic [3:0]      mem2proc_response,
    output logic [63:0]     mem2proc_data,
    output logic [3:0]      mem2proc_tag
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2,
        BUS_RSVD  = 2'd3
    } bus_cmd_e;

    logic [63:0]      mem [MEM_WORDS];
    logic [IDX_W-1:0] word_idx;
    logic             is_load;
    logic             is_store;
    logic             refuse;
    logic             accept;

    logic [3:0]  next_tag_q, next_tag_d;
    logic [3:0]  pipe_tag_q  [MEM_LATENCY];
    logic [3:0]  pipe_tag_d  [MEM_LATENCY];
    logic [63:0] pipe_data_q [MEM_LATENCY];
    logic [63:0] pipe_data_d [MEM_LATENCY];

    // Low offset bits and anything above the word index alias by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{proc2mem_addr[2:0], proc2mem_addr[XLEN-1:IDX_W+3]};

`ifdef MEM_RANDOM_REFUSE_EN
    logic [3:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
        refuse = (lfsr_q[1:0] == 2'b00);
    end

    always_ff @(posedge clock) begin
        if (reset) lfsr_q <= 4'b1001;
        else       lfsr_q <= lfsr_d;
    end
`else
    assign refuse = 1'b0;
`endif

    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        word_idx          = proc2mem_addr[IDX_W+2:3];
        is_load           = (proc2mem_command == BUS_LOAD);
        is_store          = (proc2mem_command == BUS_STORE);
        accept            = (is_load || is_store) && !reset && !refuse;
        mem2proc_response = accept ? next_tag_q : 4'd0;

        next_tag_d = next_tag_q;
        if (accept) next_tag_d = (next_tag_q == 4'd15) ? 4'd1 : next_tag_q + 4'd1;

        // Stage 0 samples the array before this cycle's write lands; empty slots carry tag 0 and data 0.
        pipe_tag_d[0]  = (accept && is_load) ? next_tag_q    : 4'd0;
        pipe_data_d[0] = (accept && is_load) ? mem[word_idx] : 64'd0;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            pipe_tag_d[i]  = pipe_tag_q[i-1];
            pipe_data_d[i] = pipe_data_q[i-1];
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            next_tag_q <= 4'd1;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                pipe_tag_q[i]  <= 4'd0;
                pipe_data_q[i] <= 64'd0;
            end
        end else begin
            next_tag_q <= next_tag_d;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                pipe_tag_q[i]  <= pipe_tag_d[i];
                pipe_data_q[i] <= pipe_data_d[i];
            end
        end
    end

    // NOTE: the storage array has no reset so it maps onto RAM; contents survive reset.
    always_ff @(posedge clock) begin
        if (accept && is_store) mem[word_idx] <= proc2mem_data;
    end

    assign mem2proc_tag  = pipe_tag_q[MEM_LATENCY-1];
    assign mem2proc_data = pipe_data_q[MEM_LATENCY-1];

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the processor/memory bus used by the caches. It accepts BUS_LOAD and BUS_STORE commands.
- Every accepted command gets a nonzero transaction tag in the same cycle.
- Each accepted load is completed exactly MEM_LATENCY cycles later by driving the tag together with the 64-bit data.
- Replaces the behavioural memory model so the cache request/response handshake can be exercised with fixed latency and optional refusals.

Parameters:
- MEM_LATENCY, 4, cycles from load acceptance to completion; legal range 1..14.
- MEM_WORDS, 8192, number of 64-bit words; covers addr[15:3].

Ports:
- clock  input  1  system clock
- reset  input  1  reset, synchronous, active-high
- proc2mem_command  input  2  0 BUS_NONE, 1 BUS_LOAD, 2 BUS_STORE, 3 treated as BUS_NONE
- proc2mem_addr  input  XLEN  byte address; only [15:3] used
- proc2mem_data  input  64  store data
- mem2proc_response  output  4  combinational; nonzero tag = command accepted this cycle, 0 = not accepted
- mem2proc_data  output  64  registered; load data, valid when mem2proc_tag != 0
- mem2proc_tag  output  4  registered; tag of the load completing this cycle, 0 = none

Behaviour:
- Reset (clock clock; reset reset, synchronous, active-high):
  - next_tag = 1.
  - Pipeline valid bits, mem2proc_tag and mem2proc_data cleared to 0.
  - mem2proc_response is 0 while reset is high.
  - Memory array contents are not reset.
- Acceptance: a command is accepted when it is LOAD or STORE, reset is low, and it is not refused (see optional feature).
  - When accepted, mem2proc_response = next_tag in that same cycle.
  - Otherwise mem2proc_response = 0.
- Tag allocation:
  - next_tag advances on each accepted command: 1..15, then wraps 15 -> 1. Tag 0 is never issued.
  - In-flight loads never exceed MEM_LATENCY (at most 14), so tags are never reused while still outstanding.
- Store:
  - On acceptance, mem[addr[15:3]] <= proc2mem_data at the clock edge closing the cycle.
  - The store consumes a tag value but never produces a completion.
- Load:
  - Data is sampled from mem[addr[15:3]] in the acceptance cycle, before any write in that cycle.
  - Because at most one command is accepted per cycle, a same-cycle store to the same address cannot occur.
  - The tag and data enter a MEM_LATENCY-deep shift pipeline.
- Completion:
  - A load accepted in cycle N drives mem2proc_tag = its tag and mem2proc_data = sampled data during cycle N+MEM_LATENCY, for exactly one cycle.
  - In all other cycles mem2proc_tag = 0 and mem2proc_data = 0.
- Back-to-back: one acceptance per cycle, so completions are at most one per cycle and never collide.
- Ordering and hazards:
  - A store accepted in cycle N is visible to a load accepted in cycle N+1 or later.
  - A load accepted before a store returns the old data.
- Address: addr[2:0] and bits above 15 are ignored. Addresses that differ only in those bits alias.
- Reset mid-operation: all in-flight loads are dropped with no completion emitted. The tag sequence restarts at 1.
- Requester holding a command across cycles: each cycle is a new command and is accepted again with a new tag. Requesters lower the command after seeing a nonzero response.

Optional Feature:
- MEM_RANDOM_REFUSE_EN defined:
  - A 4-bit LFSR (taps x^4+x^3+1, seed 4'b1001 on reset) advances every cycle.
  - When lfsr[1:0] == 2'b00, any command that cycle is refused: response 0, no write, no tag advance.
  - This exercises requester retry paths.
- MEM_RANDOM_REFUSE_EN not defined: no LFSR; every LOAD/STORE is accepted.

Test Plan:
- Reset, then STORE addr 0x0010 data 0xDEADBEEF_00000001 -> response 1 same cycle; then LOAD 0x0010 -> response 2; tag 2 with that data appears exactly 4 cycles later for 1 cycle, tag 0 before and after.
- LOAD 0x0008, 0x0010, 0x0018 in consecutive cycles after preloading words 1,2,3 = 0xA,0xB,0xC -> tags 1,2,3 completing in consecutive cycles N+4..N+6 with 0xA,0xB,0xC.
- LOAD 0x0020 in cycle N, STORE 0x0020 = 0x55 in N+1, LOAD 0x0020 in N+2 -> first completion returns old value, second returns 0x55.
- 17 back-to-back accepted commands -> tags 1..15,1,2; command 3 and BUS_NONE cycles -> response 0 with next_tag unchanged.
- LOAD accepted, reset asserted 2 cycles later for 1 cycle -> no completion ever appears; next accepted command gets tag 1.
- With MEM_RANDOM_REFUSE_EN, LOAD held continuously from reset -> response 0 exactly in cycles where lfsr[1:0]==0; every nonzero response tag completes 4 cycles later.
